// File: rtl/uart_rx_mf.sv
// ============================================================================
// uart_rx_mf : oversampled UART receiver with break detection and a receive
//              FIFO that stores per-frame parity/framing error flags.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module uart_rx_mf #(
  parameter int CLK_PER_HALF_BIT = 500,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rdata,
  output logic                          rperr,
  output logic                          rferr,
  output logic                          rvalid,
  input  logic                          rready,
  output logic                          overrun,
  output logic                          brk,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int c_cnt_w = $clog2(2*CLK_PER_HALF_BIT);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_ent_w = DATA_BITS + 2;

  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLK_PER_HALF_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_full_last = c_cnt_w'(2*CLK_PER_HALF_BIT - 1);
  localparam logic [3:0]         c_last_data = 4'(DATA_BITS - 1);
  localparam logic [3:0]         c_last_stop = 4'(STOP_BITS - 1);
  localparam logic               c_odd       = 1'(PARITY == 2);
  localparam logic [c_ptr_w:0]   c_depth     = (c_ptr_w+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PAR     = 3'd3,
    STOP    = 3'd4,
    BRKWAIT = 3'd5
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [2:0]             r_sync;
  logic                   w_rxs;
  logic [c_cnt_w-1:0]     r_cnt;
  logic [3:0]             r_bitcnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_perr, r_ferr, r_par_zero;
  logic                   r_push, r_brk;
  logic [c_ent_w-1:0]     r_push_word;
  logic                   w_tick, w_break, w_ferr_nxt;
  logic                   w_push_set, w_brk_set;

  assign w_rxs      = r_sync[2];
  assign w_tick     = (r_state == START) ? (r_cnt == c_half_last) : (r_cnt == c_full_last);
  assign w_ferr_nxt = r_ferr | ~w_rxs;
  // Break needs every data bit, the parity bit and the first stop sample low.
  assign w_break    = (r_bitcnt == 4'd0) && !w_rxs && (r_shift == '0) && r_par_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_push_set  = 1'b0;
    w_brk_set   = 1'b0;
    case (r_state)
      IDLE:    if (!w_rxs) w_state_nxt = START;
      START:   if (w_tick) w_state_nxt = w_rxs ? IDLE : DATA;
      DATA:    if (w_tick && (r_bitcnt == c_last_data))
                 w_state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:     if (w_tick) w_state_nxt = STOP;
      STOP: begin
        if (w_tick) begin
          if (w_break) begin
            w_state_nxt = BRKWAIT;
            w_brk_set   = 1'b1;
          end else if (r_bitcnt == c_last_stop) begin
            w_state_nxt = IDLE;
            w_push_set  = 1'b1;
          end
        end
      end
      BRKWAIT: if (w_rxs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync      <= 3'b111;
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_par_zero  <= 1'b1;
      r_push      <= 1'b0;
      r_brk       <= 1'b0;
      r_push_word <= '0;
    end else begin
      r_sync <= {r_sync[1:0], rxd};
      r_push <= w_push_set;
      r_brk  <= w_brk_set;
      if (r_state == IDLE || r_state == BRKWAIT || w_tick) r_cnt <= '0;
      else                                                  r_cnt <= r_cnt + c_cnt_w'(1);
      if (r_state == IDLE) begin
        r_bitcnt   <= '0;
        r_perr     <= 1'b0;
        r_ferr     <= 1'b0;
        r_par_zero <= 1'b1;
      end
      if (w_tick) begin
        case (r_state)
          DATA: begin
            r_shift  <= {w_rxs, r_shift[DATA_BITS-1:1]};
            r_bitcnt <= (r_bitcnt == c_last_data) ? 4'd0 : r_bitcnt + 4'd1;
          end
          PAR: begin
            r_perr     <= (^r_shift) ^ w_rxs ^ c_odd;
            r_par_zero <= ~w_rxs;
          end
          STOP: begin
            r_ferr   <= w_ferr_nxt;
            r_bitcnt <= r_bitcnt + 4'd1;
          end
          default: ;
        endcase
      end
      if (w_push_set) r_push_word <= {r_perr, w_ferr_nxt, r_shift};
    end
  end

  // Receive FIFO with a registered head entry.
  logic [c_ent_w-1:0]  r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [c_ptr_w:0]    r_count, w_count_nxt, w_remain;
  logic [c_ent_w-1:0]  r_head, w_head_nxt;
  logic                r_rvalid, r_overrun;
  logic                w_pop, w_full, w_wr;

  assign w_pop    = r_rvalid && rready;
  assign w_full   = (r_count == c_depth);
  assign w_wr     = r_push && (!w_full || w_pop);
  assign w_rd_nxt = w_pop ? r_rd_ptr + c_ptr_w'(1) : r_rd_ptr;
  assign w_remain = r_count - {{c_ptr_w{1'b0}}, w_pop};

  always_comb begin
    w_count_nxt = w_remain + {{c_ptr_w{1'b0}}, w_wr};
    w_head_nxt  = r_head;
    if (w_count_nxt != '0) begin
      if (w_wr && (w_remain == '0)) w_head_nxt = r_push_word;
      else                          w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_word;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_head    <= '0;
      r_rvalid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      r_rd_ptr  <= w_rd_nxt;
      r_count   <= w_count_nxt;
      r_head    <= w_head_nxt;
      r_rvalid  <= (w_count_nxt != '0);
      r_overrun <= r_push && w_full && !w_pop;
    end
  end

  assign rdata   = r_head[DATA_BITS-1:0];
  assign rferr   = r_head[DATA_BITS];
  assign rperr   = r_head[DATA_BITS+1];
  assign rvalid  = r_rvalid;
  assign overrun = r_overrun;
  assign brk     = r_brk;
  assign count   = r_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_mf.sv
// ============================================================================
// tb_uart_rx_mf : directed bench over four uart_rx_mf configurations.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_mf;

  localparam int CPH = 4;
  localparam int BIT = 2*CPH;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] rxd;
  logic [3:0] rready;
  logic [7:0] rdata [4];
  logic [3:0] rperr, rferr, rvalid, overrun, brk;
  logic [4:0] count_a, count_b, count_c;
  logic [2:0] count_d;

  int n_vec = 0;
  int n_err = 0;
  int n_brk [4] = '{0, 0, 0, 0};
  int n_ovr [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  // a: defaults, b: even parity, c: two stop bits, d: 4-entry FIFO
  uart_rx_mf #(.CLK_PER_HALF_BIT(CPH)) u_a (
    .clk(clk), .rstn(rstn), .rxd(rxd[0]), .rdata(rdata[0]), .rperr(rperr[0]),
    .rferr(rferr[0]), .rvalid(rvalid[0]), .rready(rready[0]), .overrun(overrun[0]),
    .brk(brk[0]), .count(count_a));
  uart_rx_mf #(.CLK_PER_HALF_BIT(CPH), .PARITY(1)) u_b (
    .clk(clk), .rstn(rstn), .rxd(rxd[1]), .rdata(rdata[1]), .rperr(rperr[1]),
    .rferr(rferr[1]), .rvalid(rvalid[1]), .rready(rready[1]), .overrun(overrun[1]),
    .brk(brk[1]), .count(count_b));
  uart_rx_mf #(.CLK_PER_HALF_BIT(CPH), .STOP_BITS(2)) u_c (
    .clk(clk), .rstn(rstn), .rxd(rxd[2]), .rdata(rdata[2]), .rperr(rperr[2]),
    .rferr(rferr[2]), .rvalid(rvalid[2]), .rready(rready[2]), .overrun(overrun[2]),
    .brk(brk[2]), .count(count_c));
  uart_rx_mf #(.CLK_PER_HALF_BIT(CPH), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .rstn(rstn), .rxd(rxd[3]), .rdata(rdata[3]), .rperr(rperr[3]),
    .rferr(rferr[3]), .rvalid(rvalid[3]), .rready(rready[3]), .overrun(overrun[3]),
    .brk(brk[3]), .count(count_d));

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (brk[i])     n_brk[i]++;
      if (overrun[i]) n_ovr[i]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bits go out LSB first, one bit period each, followed by idle line.
  task automatic send(input int ch, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd[ch] = bits[i];
      repeat (BIT) @(negedge clk);
    end
    rxd[ch] = 1'b1;
    repeat (2*BIT) @(negedge clk);
  endtask

  task automatic pop(input int ch);
    rready[ch] = 1'b1;
    @(negedge clk);
    rready[ch] = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    rstn   = 1'b0;
    rxd    = 4'hf;
    rready = 4'h0;
    repeat (4) @(negedge clk);
    chk("rst_rvalid",  32'(rvalid[0]),  0);
    chk("rst_rdata",   32'(rdata[0]),   0);
    chk("rst_rperr",   32'(rperr[0]),   0);
    chk("rst_rferr",   32'(rferr[0]),   0);
    chk("rst_overrun", 32'(overrun[0]), 0);
    chk("rst_brk",     32'(brk[0]),     0);
    chk("rst_count_a", 32'(count_a),    0);
    chk("rst_count_d", 32'(count_d),    0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5, one stop bit
    send(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10);
    chk("a5_rvalid", 32'(rvalid[0]), 1);
    chk("a5_rdata",  32'(rdata[0]),  32'hA5);
    chk("a5_rperr",  32'(rperr[0]),  0);
    chk("a5_rferr",  32'(rferr[0]),  0);
    chk("a5_count",  32'(count_a),   1);
    pop(0);
    chk("a5_popped_rvalid", 32'(rvalid[0]), 0);
    chk("a5_popped_count",  32'(count_a),   0);

    // Even parity on 0x07: parity bit 0 is wrong, 1 is right
    send(1, {5'h1f, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    chk("par0_rdata", 32'(rdata[1]), 32'h07);
    chk("par0_rperr", 32'(rperr[1]), 1);
    chk("par0_rferr", 32'(rferr[1]), 0);
    pop(1);
    send(1, {5'h1f, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    chk("par1_rdata", 32'(rdata[1]), 32'h07);
    chk("par1_rperr", 32'(rperr[1]), 0);
    pop(1);
    chk("par_count", 32'(count_b), 0);

    // Two stop bits: bad second stop on 0x3C, then a clean 0x11
    send(2, {5'h1f, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    send(2, {5'h1f, 1'b1, 1'b1, 8'h11, 1'b0}, 11);
    chk("stop2_count", 32'(count_c),  2);
    chk("stop2_rdata", 32'(rdata[2]), 32'h3C);
    chk("stop2_rferr", 32'(rferr[2]), 1);
    pop(2);
    chk("next_rdata", 32'(rdata[2]), 32'h11);
    chk("next_rferr", 32'(rferr[2]), 0);
    chk("next_rperr", 32'(rperr[2]), 0);
    pop(2);
    chk("stop2_empty", 32'(rvalid[2]), 0);

    // Depth-4 FIFO with no consumer: fifth frame overruns
    for (int k = 1; k <= 4; k++) begin
      v = k[7:0];
      send(3, {6'h3f, 1'b1, v, 1'b0}, 10);
    end
    chk("full_count",   32'(count_d),  4);
    chk("full_no_ovr",  32'(n_ovr[3]), 0);
    send(3, {6'h3f, 1'b1, 8'h05, 1'b0}, 10);
    chk("ovr_pulses",   32'(n_ovr[3]), 1);
    chk("ovr_count",    32'(count_d),  4);
    chk("ovr_head",     32'(rdata[3]), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("pop_rdata", 32'(rdata[3]), 32'(k));
      pop(3);
    end
    chk("drained_rvalid", 32'(rvalid[3]), 0);
    chk("drained_count",  32'(count_d),   0);

    // Line held low for 20 bit periods
    rxd[0] = 1'b0;
    repeat (20*BIT) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (4*BIT) @(negedge clk);
    chk("brk_pulses", 32'(n_brk[0]), 1);
    chk("brk_count",  32'(count_a),  0);
    chk("brk_rvalid", 32'(rvalid[0]), 0);
    send(0, {6'h3f, 1'b1, 8'h55, 1'b0}, 10);
    chk("post_brk_rdata", 32'(rdata[0]), 32'h55);
    chk("post_brk_count", 32'(count_a),  1);
    pop(0);

    // Short low glitch must be rejected as a false start
    rxd[0] = 1'b0;
    repeat (CPH-2) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (4*BIT) @(negedge clk);
    chk("glitch_count",  32'(count_a),   0);
    chk("glitch_rvalid", 32'(rvalid[0]), 0);
    send(0, {6'h3f, 1'b1, 8'h3A, 1'b0}, 10);
    chk("post_glitch_rdata", 32'(rdata[0]), 32'h3A);
    chk("post_glitch_count", 32'(count_a),  1);

    // Reset mid-frame with an entry still queued
    rxd[0] = 1'b0;
    repeat (BIT) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (BIT) @(negedge clk);
    rxd[0] = 1'b0;
    repeat (3) @(negedge clk);
    rstn   = 1'b0;
    rxd[0] = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (12*BIT) @(negedge clk);
    chk("midrst_rvalid", 32'(rvalid[0]), 0);
    chk("midrst_count",  32'(count_a),   0);
    chk("midrst_rdata",  32'(rdata[0]),  0);
    chk("midrst_rperr",  32'(rperr[0]),  0);
    chk("midrst_rferr",  32'(rferr[0]),  0);
    chk("midrst_brk",    32'(n_brk[0]),  1);
    chk("midrst_ovr",    32'(n_ovr[0]),  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_mf.md
UART_RX_MF -- requirements
Module: uart_rx_mf

Interface
REQ-001 SHALL have parameter CLK_PER_HALF_BIT, default 500: clk cycles per half bit period; legal range >= 2.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16: receive FIFO entries; power of 2, >= 2.
REQ-006 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-007 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port rxd, input, 1: asynchronous serial line, idle high.
REQ-009 SHALL have port rdata, output, DATA_BITS: FIFO head data.
REQ-010 SHALL have port rperr, output, 1: parity-error flag stored with the FIFO head.
REQ-011 SHALL have port rferr, output, 1: framing-error flag stored with the FIFO head.
REQ-012 SHALL have port rvalid, output, 1: FIFO non-empty.
REQ-013 SHALL have port rready, input, 1: consumer pops the head when rvalid && rready.
REQ-014 SHALL have port overrun, output, 1: one-cycle pulse when a frame is dropped because the FIFO is full.
REQ-015 SHALL have port brk, output, 1: one-cycle pulse on break detection.
REQ-016 SHALL have port count, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-017 SHALL pass rxd through a 3-flop synchroniser reset to 3'b111; all sampling SHALL use the third stage (rxs).
REQ-018 SHALL implement states IDLE, START, DATA, PAR, STOP, BRKWAIT.
REQ-019 IDLE: on rxs==0, SHALL go to START and clear the bit counter.
REQ-020 START: after CLK_PER_HALF_BIT cycles, SHALL sample rxs. If 1 (false start), SHALL return to IDLE and push nothing. If 0, SHALL go to DATA.
REQ-021 DATA/PAR/STOP: each sample SHALL be taken exactly 2*CLK_PER_HALF_BIT cycles after the previous sample.
REQ-022 DATA SHALL shift in DATA_BITS samples LSB first, then go to PAR if PARITY!=0, else to STOP.
REQ-023 PAR: perr SHALL be set when (XOR of data bits ^ parity sample) != (PARITY==2).
REQ-024 STOP SHALL take STOP_BITS samples; ferr SHALL be set if any stop sample is 0.
REQ-025 After the last stop sample, SHALL return to IDLE on the next cycle; a start bit beginning immediately afterwards SHALL be received.
REQ-026 Break: if all data bits, the parity bit (if present) and the first stop sample are all 0, SHALL pulse brk for one cycle, push nothing, and go to BRKWAIT.
REQ-027 BRKWAIT SHALL stay until rxs==1, then go to IDLE.
REQ-028 Non-break frames SHALL be pushed as {perr,ferr,data} on the cycle after the last stop sample, including frames with errors.
REQ-029 rvalid, rdata, rperr and rferr SHALL be registered FIFO-head outputs; rvalid SHALL rise the cycle after a push into an empty FIFO.
REQ-030 Pop SHALL occur when rvalid && rready; the next entry (or rvalid=0) SHALL appear the following cycle.
REQ-031 Push with FIFO full and no simultaneous pop: the frame SHALL be dropped, overrun SHALL pulse for one cycle, and FIFO contents SHALL be unchanged.
REQ-032 Push and pop in the same cycle with FIFO full SHALL succeed with no overrun; count SHALL be unchanged.
REQ-033 Push and pop in the same cycle with FIFO empty SHALL be impossible, since pop requires rvalid.
REQ-034 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH.
REQ-035 rdata with rvalid=0 SHALL be don't-care; rdata SHALL hold its value while rvalid && !rready.

Reset
REQ-036 On rstn==0 at a clk edge, SHALL set state=IDLE, synchroniser=3'b111, counters=0, FIFO empty.
REQ-037 On reset, SHALL set rvalid=0, rdata=0, rperr=0, rferr=0, overrun=0, brk=0, count=0.
REQ-038 Reset mid-frame SHALL abort the frame with no push; after release, reception SHALL resume only at a new falling edge on rxs.

Verification
REQ-039 Defaults with CLK_PER_HALF_BIT=4: send 0xA5 with a valid stop -> one entry rdata=0xA5, rperr=0, rferr=0, count=1.
REQ-040 PARITY=1, send 0x07 with parity bit 0 -> rdata=0x07, rperr=1; with parity bit 1 -> rperr=0.
REQ-041 STOP_BITS=2, send 0x3C with second stop=0 -> rdata=0x3C, rferr=1; a following frame 0x11 SHALL still be received correctly.
REQ-042 FIFO_DEPTH=4, rready=0, send 5 frames 0x01..0x05 -> count=4, one overrun pulse at frame 5; pops SHALL return 0x01..0x04.
REQ-043 Hold rxd=0 for 20 bit periods, then release high -> exactly one brk pulse, count=0; next frame 0x55 received.
REQ-044 rxd low-glitch of CLK_PER_HALF_BIT-2 cycles -> no push, state back to IDLE; also assert rstn=0 mid-frame -> no push, all outputs 0.
